// File: rtl/c_sel_a_pkg.sv
// Shared defaults and helpers for the pipelined carry-select adder.
package c_sel_a_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int SEG_DEF   = 8;

  // Number of carry-select segments, and so the number of pipeline stages.
  function automatic int nseg(input int width, input int seg);
    return width / seg;
  endfunction
endpackage

// File: rtl/c_sel_a_seg.sv
// Combinational SEG-bit carry-select segment: both carry-in cases are summed
// up front, and the late-arriving carry only drives the final mux.
module c_sel_a_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           ci_i,
  output logic [SEG-1:0] s_o,
  output logic           co_o
);
  logic [SEG:0] r0, r1;

  assign r0 = {1'b0, a_i} + {1'b0, b_i};
  assign r1 = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, 1'b1};

  assign s_o  = ci_i ? r1[SEG-1:0] : r0[SEG-1:0];
  assign co_o = ci_i ? r1[SEG]     : r0[SEG];
endmodule

// File: rtl/c_sel_a_pipe.sv
// Pipelined carry-select adder/subtractor, one stage per SEG-bit segment.
// Stage k resolves segment k from the registered carry of stage k-1; the
// operand bits still to be summed travel upward with the beat, resolved sum
// bits travel forward. The last stage is the output register.
// Optional macro C_SEL_A_PIPE_OVF_EN adds a registered signed-overflow output.
module c_sel_a_pipe
  import c_sel_a_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG   = SEG_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:1] A,
  input  logic [WIDTH:1] B,
  input  logic           cin,
  input  logic           sub,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:1] S,
  output logic           cout
`ifdef C_SEL_A_PIPE_OVF_EN
  ,
  output logic           ovf
`endif
);
  localparam int NSEG = nseg(WIDTH, SEG);
  localparam int LP   = NSEG - 1;

  if ((WIDTH % SEG) != 0 || WIDTH < 2 * SEG) begin : g_bad_param
    $error("c_sel_a_pipe: WIDTH must be a multiple of SEG and at least 2*SEG");
  end

  logic             adv;
  logic [WIDTH-1:0] a0, b0;
  logic             c0;
  logic             vld_out_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q;

  // The whole pipe moves as one: any free output slot lets every stage shift.
  assign adv      = !vld_out_q || out_ready;
  assign in_ready = adv;

  // Subtraction folds into the operands at acceptance, so sub/cin never
  // need to travel separately.
  assign a0 = A;
  assign b0 = sub ? ~B : B;
  assign c0 = sub | cin;

  for (genvar k = 1; k < NSEG; k++) begin : g_st
    localparam int LO = k * SEG;
    localparam int HI = WIDTH - LO;

    logic          vld_q, vld_d, c_q, c_d;
    logic [LO-1:0] s_q, s_d;
    logic [HI-1:0] a_q, a_d, b_q, b_d;
    logic [SEG-1:0] sa, sb, ss;
    logic          sci, sco;

    c_sel_a_seg #(.SEG(SEG)) u_seg (
      .a_i(sa), .b_i(sb), .ci_i(sci), .s_o(ss), .co_o(sco)
    );

    if (k == 1) begin : g_first
      assign sa    = a0[SEG-1:0];
      assign sb    = b0[SEG-1:0];
      assign sci   = c0;
      assign vld_d = in_valid;
      assign s_d   = ss;
      assign a_d   = a0[WIDTH-1:SEG];
      assign b_d   = b0[WIDTH-1:SEG];
    end else begin : g_mid
      assign sa    = g_st[k-1].a_q[SEG-1:0];
      assign sb    = g_st[k-1].b_q[SEG-1:0];
      assign sci   = g_st[k-1].c_q;
      assign vld_d = g_st[k-1].vld_q;
      assign s_d   = {ss, g_st[k-1].s_q};
      assign a_d   = g_st[k-1].a_q[HI+SEG-1:SEG];
      assign b_d   = g_st[k-1].b_q[HI+SEG-1:SEG];
    end

    assign c_d = sco;

    // Stage register: shifts on advance, holds on stall, cleared on reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= '0;
        a_q   <= '0;
        b_q   <= '0;
      end else if (adv) begin
        vld_q <= vld_d;
        c_q   <= c_d;
        s_q   <= s_d;
        a_q   <= a_d;
        b_q   <= b_d;
      end
    end
  end

  logic [SEG-1:0] la, lb, ls;
  logic           lco;

  assign la = g_st[LP].a_q;
  assign lb = g_st[LP].b_q;

  c_sel_a_seg #(.SEG(SEG)) u_seg_last (
    .a_i(la), .b_i(lb), .ci_i(g_st[LP].c_q), .s_o(ls), .co_o(lco)
  );

  assign sum_d = {ls, g_st[LP].s_q};

  // Output stage: result only loads for a real beat, so bubbles leave S alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_out_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else if (adv) begin
      vld_out_q <= g_st[LP].vld_q;
      if (g_st[LP].vld_q) begin
        sum_q  <= sum_d;
        cout_q <= lco;
      end
    end
  end

`ifdef C_SEL_A_PIPE_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: operands share a sign that the result does not.
  assign ovf_d = (la[SEG-1] == lb[SEG-1]) && (ls[SEG-1] != la[SEG-1]);

  // Overflow flag registered alongside S.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv && g_st[LP].vld_q) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign out_valid = vld_out_q;
  assign S         = sum_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_c_sel_a_pipe.sv
// Scoreboard bench for c_sel_a_pipe (WIDTH=32, SEG=8): directed vectors with
// hand-computed results, a stalled burst, mid-flight reset, short random run.
module tb_c_sel_a_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W:1]   A = '0, B = '0;
  logic         cin = 1'b0, sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W:1]   S;
  logic         cout;
`ifdef C_SEL_A_PIPE_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic         ci, sb;
    logic [W-1:0] s;
    logic         c, o;
  } vec_t;

  vec_t tv [12] = '{
    '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
    '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0},
    '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1},
    '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0},
    '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1},
    '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0},
    '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1},
    '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0},
    '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0},
    '{32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_000D, 1'b1, 1'b0},
    '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0}
  };

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   st_lo = -1, st_hi = -1;
  bit   rdy_rand = 1'b0;

  c_sel_a_pipe #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .cout(cout)
`ifdef C_SEL_A_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, b, input logic ci, sb);
    logic [W-1:0] bb;
    logic [W:0]   t;
    exp_t         e;
    bb  = sb ? ~b : b;
    t   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sb | ci)};
    e.s = t[W-1:0];
    e.c = t[W];
    e.o = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return e;
  endfunction

  // Consumer-side ready: fixed stall window or random, updated off the edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    else          out_ready = !(cyc >= st_lo && cyc <= st_hi);
  end

  // Monitor: whenever a result is presented, compare against the queue head;
  // pop only on transfer, so stalled cycles re-check the held value.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious: out_valid with S=%h, expected no result", S);
        end else begin
          chk("S", {32'd0, S}, {32'd0, q[0].s});
          chk("cout", {63'd0, cout}, {63'd0, q[0].c});
`ifdef C_SEL_A_PIPE_OVF_EN
          chk("ovf", {63'd0, ovf}, {63'd0, q[0].o});
`endif
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  // Present one beat until accepted; expected result queued at acceptance.
  task automatic drive(input logic [W-1:0] a, b, input logic ci, sb, input exp_t e);
    int tries = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; A = a; B = b; cin = ci; sub = sb;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        break;
      end
      tries++;
      if (tries > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: beat not accepted, expected acceptance");
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_vec(input int i);
    exp_t e;
    e.s = tv[i].s; e.c = tv[i].c; e.o = tv[i].o;
    drive(tv[i].a, tv[i].b, tv[i].ci, tv[i].sb, e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int lat;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_S", {32'd0, S}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    rst = 1'b0;

    // Full-width ripple and latency with no stall
    drive_vec(0);
    idle();
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk("latency", 64'(lat), 64'd4);
    drain();

    // All directed vectors, back to back
    for (int i = 0; i < 12; i++) drive_vec(i);
    idle();
    drain();

    // 8-beat burst with consumer stalled for three cycles
    st_lo = cyc + 6;
    st_hi = cyc + 8;
    for (int i = 0; i < 8; i++) drive_vec(i + 2);
    idle();
    drain();
    st_lo = -1;
    st_hi = -1;

    // Reset with two beats in flight: both must vanish
    drive_vec(3);
    drive_vec(4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_S", {32'd0, S}, 64'd0);
    chk("midrst_cout", {63'd0, cout}, 64'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Random operands with random valid/ready
    rdy_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        logic [W-1:0] ra, rb;
        logic rc, rs;
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        drive(ra, rb, rc, rs, model(ra, rb, rc, rs));
      end
    end
    idle();
    rdy_rand = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
